// File: rtl/control_sequencer.sv
// Purpose : step sequencer + instruction latch driving the datapath strobes for a small register machine.
// Latency : 4 cycles FETCH-to-FETCH (3 for non-ALU ops when FAST_NONALU=1); strobes are combinational from state.
// Backpressure: iin_ready is high only in FETCH; iin/iin_valid are ignored in all other states and in HALT.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset (overrides every state)
//   iin, iin_valid    instruction word {opcode, rx, ry} and its valid flag
//   iin_ready         high while the sequencer waits in FETCH
//   mux_select        bus source: {0,rx}/{0,ry}, IMM={1,0..0}, ALU_OUT={1,0..01}, none=all ones
//   regs_enable       one-hot register write enable (T3 of write ops)
//   alu_op_select     ALU op for ALU instructions, 2'b11 otherwise
//   a_reg_enable, alu_reg_enable, imm_wr_enable, pc_wr_enable   datapath load strobes
//   branch_select     latched instruction is BEZ (T1..T3)
//   halted, step      HALT indication and current step (FETCH=0, T1=1, T2=2, T3/HALT=3)
//   retired           wrapping count of completed instructions

module control_sequencer #(
    parameter int REG_ADDR_W  = 3,
    parameter int OPCODE_W    = 3,
    parameter int FAST_NONALU = 0,
    parameter int CNT_W       = 16,
    localparam int NUM_REGS   = 2**REG_ADDR_W,
    localparam int IIN_W      = OPCODE_W + 2*REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [IIN_W-1:0]      iin,
    input  logic                  iin_valid,
    output logic                  iin_ready,
    output logic [REG_ADDR_W:0]   mux_select,
    output logic [NUM_REGS-1:0]   regs_enable,
    output logic [1:0]            alu_op_select,
    output logic                  a_reg_enable,
    output logic                  alu_reg_enable,
    output logic                  imm_wr_enable,
    output logic                  pc_wr_enable,
    output logic                  branch_select,
    output logic                  halted,
    output logic [1:0]            step,
    output logic [CNT_W-1:0]      retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_T1,
        S_T2,
        S_T3,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NAN = 3'b010;
    localparam logic [2:0] OP_HLT = 3'b011;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_BEZ = 3'b110;
    localparam logic [2:0] OP_REP = 3'b111;

    localparam logic [REG_ADDR_W:0] MUX_NONE = '1;
    localparam logic [REG_ADDR_W:0] MUX_IMM  = {1'b1, {REG_ADDR_W{1'b0}}};
    localparam logic [REG_ADDR_W:0] MUX_ALU  = MUX_IMM | (REG_ADDR_W+1)'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic [IIN_W-1:0]       instr_q;
    logic [CNT_W-1:0]       retired_q;

    // Field decode of the latched instruction.
    logic [OPCODE_W-1:0]    opc;
    logic [REG_ADDR_W-1:0]  rx;
    logic [REG_ADDR_W-1:0]  ry;
    logic                   op_ok;
    logic                   is_alu;
    logic                   is_hlt;
    logic                   is_out;
    logic                   is_ldi;
    logic                   is_bez;
    logic                   is_rep;
    logic                   is_write;

    assign opc = instr_q[IIN_W-1 -: OPCODE_W];
    assign rx  = instr_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign ry  = instr_q[REG_ADDR_W-1:0];

    // Any set bit above the decoded low three makes the instruction a no-op:
    // every class flag drops, so it writes nothing but still walks to T3 and bumps the PC.
    assign op_ok    = ((opc >> 3) == '0);
    assign is_alu   = op_ok && (opc[2:0] == OP_ADD || opc[2:0] == OP_SUB || opc[2:0] == OP_NAN);
    assign is_hlt   = op_ok && (opc[2:0] == OP_HLT);
    assign is_out   = op_ok && (opc[2:0] == OP_OUT);
    assign is_ldi   = op_ok && (opc[2:0] == OP_LDI);
    assign is_bez   = op_ok && (opc[2:0] == OP_BEZ);
    assign is_rep   = op_ok && (opc[2:0] == OP_REP);
    assign is_write = is_alu || is_ldi || is_rep;

    assign retired = retired_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && iin_valid) begin
                instr_q <= iin;
            end
            if (state_q == S_T3) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        iin_ready      = 1'b0;
        mux_select     = MUX_NONE;
        regs_enable    = '0;
        a_reg_enable   = 1'b0;
        alu_reg_enable = 1'b0;
        imm_wr_enable  = 1'b0;
        pc_wr_enable   = 1'b0;
        branch_select  = 1'b0;
        halted         = 1'b0;
        step           = 2'd3;
        alu_op_select  = is_alu ? opc[1:0] : 2'b11;

        case (state_q)
            S_FETCH: begin
                step          = 2'd0;
                iin_ready     = 1'b1;
                imm_wr_enable = iin_valid;
                if (iin_valid) begin
                    state_d = S_T1;
                end
            end
            S_T1: begin
                step          = 2'd1;
                branch_select = is_bez;
                if (is_hlt) begin
                    state_d = S_HALT;
                end else if (is_alu) begin
                    mux_select   = {1'b0, rx};
                    a_reg_enable = 1'b1;
                    state_d      = S_T2;
                end else begin
                    state_d = (FAST_NONALU != 0) ? S_T3 : S_T2;
                end
            end
            S_T2: begin
                step          = 2'd2;
                branch_select = is_bez;
                if (is_alu) begin
                    mux_select     = {1'b0, ry};
                    alu_reg_enable = 1'b1;
                end
                state_d = S_T3;
            end
            S_T3: begin
                step          = 2'd3;
                branch_select = is_bez;
                if (is_out || is_bez) begin
                    mux_select = {1'b0, rx};
                end else if (is_rep) begin
                    mux_select = {1'b0, ry};
                end else if (is_ldi) begin
                    mux_select = MUX_IMM;
                end else if (is_alu) begin
                    mux_select = MUX_ALU;
                end
                if (is_write) begin
                    regs_enable = NUM_REGS'(1) << rx;
                end
                pc_wr_enable = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT: begin
                step   = 2'd3;
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset masks every strobe in the same cycle, whatever the state register holds.
        if (reset) begin
            state_d        = S_FETCH;
            iin_ready      = 1'b0;
            mux_select     = MUX_NONE;
            regs_enable    = '0;
            a_reg_enable   = 1'b0;
            alu_reg_enable = 1'b0;
            imm_wr_enable  = 1'b0;
            pc_wr_enable   = 1'b0;
            branch_select  = 1'b0;
            halted         = 1'b0;
            alu_op_select  = 2'b11;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // Instance 0: default parameters (slow non-ALU path, 16-bit counter).
    logic [8:0]  iin0;
    logic        v0, rdy0, a0, l0, imm0, pc0, br0, h0;
    logic [3:0]  mux0;
    logic [7:0]  regs0;
    logic [1:0]  aop0, st0;
    logic [15:0] ret0;

    // Instance 1: fast non-ALU path, 4-bit opcode, 4-bit counter for the wrap test.
    logic [9:0]  iin1;
    logic        v1, rdy1, a1, l1, imm1, pc1, br1, h1;
    logic [3:0]  mux1;
    logic [7:0]  regs1;
    logic [1:0]  aop1, st1;
    logic [3:0]  ret1;

    control_sequencer dut0 (
        .clock(clock), .reset(reset), .iin(iin0), .iin_valid(v0), .iin_ready(rdy0),
        .mux_select(mux0), .regs_enable(regs0), .alu_op_select(aop0),
        .a_reg_enable(a0), .alu_reg_enable(l0), .imm_wr_enable(imm0), .pc_wr_enable(pc0),
        .branch_select(br0), .halted(h0), .step(st0), .retired(ret0)
    );

    control_sequencer #(.REG_ADDR_W(3), .OPCODE_W(4), .FAST_NONALU(1), .CNT_W(4)) dut1 (
        .clock(clock), .reset(reset), .iin(iin1), .iin_valid(v1), .iin_ready(rdy1),
        .mux_select(mux1), .regs_enable(regs1), .alu_op_select(aop1),
        .a_reg_enable(a1), .alu_reg_enable(l1), .imm_wr_enable(imm1), .pc_wr_enable(pc1),
        .branch_select(br1), .halted(h1), .step(st1), .retired(ret1)
    );

    typedef struct packed {
        logic        dut;
        logic        rst;
        logic        vld;
        logic [9:0]  iin;
        logic [1:0]  step;
        logic [3:0]  mux;
        logic [7:0]  regs;
        logic [1:0]  aop;
        logic [6:0]  sb;   // {a_reg, alu_reg, imm, pc, branch, ready, halted}
        logic [15:0] ret;
    } vec_t;

    localparam logic [6:0] A = 7'b1000000;
    localparam logic [6:0] L = 7'b0100000;
    localparam logic [6:0] I = 7'b0010000;
    localparam logic [6:0] P = 7'b0001000;
    localparam logic [6:0] B = 7'b0000100;
    localparam logic [6:0] R = 7'b0000010;
    localparam logic [6:0] H = 7'b0000001;
    localparam logic [6:0] N = 7'b0000000;

    vec_t tbl[$];
    vec_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   rowno = 0;

    function automatic vec_t row(input logic d, input logic r, input logic v, input logic [9:0] i,
                                 input logic [1:0] st, input logic [3:0] m, input logic [7:0] rg,
                                 input logic [1:0] ao, input logic [6:0] sb, input logic [15:0] rt);
        vec_t x;
        x.dut = d; x.rst = r; x.vld = v; x.iin = i; x.step = st; x.mux = m;
        x.regs = rg; x.aop = ao; x.sb = sb; x.ret = rt;
        return x;
    endfunction

    task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, rowno, got, exp);
        end
    endtask

    task automatic check(input vec_t e);
        logic [1:0]  g_st, g_aop;
        logic [3:0]  g_mux;
        logic [7:0]  g_regs;
        logic [6:0]  g_sb;
        logic [15:0] g_ret;
        if (e.dut == 1'b0) begin
            g_st = st0; g_aop = aop0; g_mux = mux0; g_regs = regs0; g_ret = ret0;
            g_sb = {a0, l0, imm0, pc0, br0, rdy0, h0};
        end else begin
            g_st = st1; g_aop = aop1; g_mux = mux1; g_regs = regs1; g_ret = {12'd0, ret1};
            g_sb = {a1, l1, imm1, pc1, br1, rdy1, h1};
        end
        cmp("mux_select", {12'd0, g_mux}, {12'd0, e.mux});
        cmp("regs_enable", {8'd0, g_regs}, {8'd0, e.regs});
        cmp("alu_op_select", {14'd0, g_aop}, {14'd0, e.aop});
        cmp("strobes{a,alu,imm,pc,br,rdy,halt}", {9'd0, g_sb}, {9'd0, e.sb});
        // Step and counter during a reset cycle still show the pre-reset register contents.
        if (!e.rst) begin
            cmp("step", {14'd0, g_st}, {14'd0, e.step});
            cmp("retired", g_ret, e.ret);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge clock);
        #1;
        reset = v.rst;
        if (v.dut == 1'b0) begin
            iin0 = v.iin[8:0]; v0 = v.vld; iin1 = '0; v1 = 1'b0;
        end else begin
            iin1 = v.iin; v1 = v.vld; iin0 = '0; v0 = 1'b0;
        end
        sbq.push_back(v);
        @(negedge clock);
        e = sbq.pop_front();
        check(e);
        rowno++;
    endtask

    initial begin
        reset = 1'b1; iin0 = '0; v0 = 1'b0; iin1 = '0; v1 = 1'b0;

        // ---- table for instance 0 ----
        tbl.push_back(row(0,1,0,10'h000, 0,4'hF,8'h00,2'd3, N, 0));
        tbl.push_back(row(0,1,0,10'h000, 0,4'hF,8'h00,2'd3, N, 0));
        // ADD r1,r2; garbage on iin outside FETCH is ignored
        tbl.push_back(row(0,0,1,10'h00A, 0,4'hF,8'h00,2'd0, I|R, 0));
        tbl.push_back(row(0,0,0,10'h1FF, 1,4'h1,8'h00,2'd0, A, 0));
        tbl.push_back(row(0,0,1,10'h1FF, 2,4'h2,8'h00,2'd0, L, 0));
        tbl.push_back(row(0,0,0,10'h000, 3,4'h9,8'h02,2'd0, P, 0));
        // BEZ r3
        tbl.push_back(row(0,0,1,10'h198, 0,4'hF,8'h00,2'd0, I|R, 1));
        tbl.push_back(row(0,0,0,10'h000, 1,4'hF,8'h00,2'd3, B, 1));
        tbl.push_back(row(0,0,0,10'h000, 2,4'hF,8'h00,2'd3, B, 1));
        tbl.push_back(row(0,0,0,10'h000, 3,4'h3,8'h00,2'd3, B|P, 1));
        // SUB r2,r4
        tbl.push_back(row(0,0,1,10'h054, 0,4'hF,8'h00,2'd3, I|R, 2));
        tbl.push_back(row(0,0,0,10'h000, 1,4'h2,8'h00,2'd1, A, 2));
        tbl.push_back(row(0,0,0,10'h000, 2,4'h4,8'h00,2'd1, L, 2));
        tbl.push_back(row(0,0,0,10'h000, 3,4'h9,8'h04,2'd1, P, 2));
        // NAN r7,r0
        tbl.push_back(row(0,0,1,10'h0B8, 0,4'hF,8'h00,2'd1, I|R, 3));
        tbl.push_back(row(0,0,0,10'h000, 1,4'h7,8'h00,2'd2, A, 3));
        tbl.push_back(row(0,0,0,10'h000, 2,4'h0,8'h00,2'd2, L, 3));
        tbl.push_back(row(0,0,0,10'h000, 3,4'h9,8'h80,2'd2, P, 3));
        // OUT r6
        tbl.push_back(row(0,0,1,10'h130, 0,4'hF,8'h00,2'd2, I|R, 4));
        tbl.push_back(row(0,0,0,10'h000, 1,4'hF,8'h00,2'd3, N, 4));
        tbl.push_back(row(0,0,0,10'h000, 2,4'hF,8'h00,2'd3, N, 4));
        tbl.push_back(row(0,0,0,10'h000, 3,4'h6,8'h00,2'd3, P, 4));
        // REP r3,r5
        tbl.push_back(row(0,0,1,10'h1DD, 0,4'hF,8'h00,2'd3, I|R, 5));
        tbl.push_back(row(0,0,0,10'h000, 1,4'hF,8'h00,2'd3, N, 5));
        tbl.push_back(row(0,0,0,10'h000, 2,4'hF,8'h00,2'd3, N, 5));
        tbl.push_back(row(0,0,0,10'h000, 3,4'h5,8'h08,2'd3, P, 5));
        // five idle cycles
        for (int k = 0; k < 5; k++) tbl.push_back(row(0,0,0,10'h00A, 0,4'hF,8'h00,2'd3, R, 6));
        // LDI r5 on the slow path, valid ignored mid-instruction
        tbl.push_back(row(0,0,1,10'h168, 0,4'hF,8'h00,2'd3, I|R, 6));
        tbl.push_back(row(0,0,1,10'h0C0, 1,4'hF,8'h00,2'd3, N, 6));
        tbl.push_back(row(0,0,0,10'h000, 2,4'hF,8'h00,2'd3, N, 6));
        tbl.push_back(row(0,0,0,10'h000, 3,4'h8,8'h20,2'd3, P, 6));
        // HLT, then valid pulses while halted
        tbl.push_back(row(0,0,1,10'h0C0, 0,4'hF,8'h00,2'd3, I|R, 7));
        tbl.push_back(row(0,0,0,10'h000, 1,4'hF,8'h00,2'd3, N, 7));
        tbl.push_back(row(0,0,1,10'h00A, 3,4'hF,8'h00,2'd3, H, 7));
        tbl.push_back(row(0,0,0,10'h00A, 3,4'hF,8'h00,2'd3, H, 7));
        tbl.push_back(row(0,0,1,10'h00A, 3,4'hF,8'h00,2'd3, H, 7));
        // one reset cycle leaves HALT and clears latch and counter
        tbl.push_back(row(0,1,0,10'h000, 0,4'hF,8'h00,2'd3, N, 0));
        tbl.push_back(row(0,0,0,10'h000, 0,4'hF,8'h00,2'd0, R, 0));
        // ADD r1,r2 then SUB with reset landing in its T2
        tbl.push_back(row(0,0,1,10'h00A, 0,4'hF,8'h00,2'd0, I|R, 0));
        tbl.push_back(row(0,0,0,10'h000, 1,4'h1,8'h00,2'd0, A, 0));
        tbl.push_back(row(0,0,0,10'h000, 2,4'h2,8'h00,2'd0, L, 0));
        tbl.push_back(row(0,0,0,10'h000, 3,4'h9,8'h02,2'd0, P, 0));
        tbl.push_back(row(0,0,1,10'h054, 0,4'hF,8'h00,2'd0, I|R, 1));
        tbl.push_back(row(0,0,0,10'h000, 1,4'h2,8'h00,2'd1, A, 1));
        tbl.push_back(row(0,1,0,10'h000, 2,4'hF,8'h00,2'd3, N, 1));
        tbl.push_back(row(0,0,0,10'h000, 0,4'hF,8'h00,2'd0, R, 0));

        foreach (tbl[j]) apply(tbl[j]);

        // ---- instance 1: fast path, no-op decode, counter wrap ----
        // LDI r5: FETCH, T1, T3, FETCH again three cycles after the first
        apply(row(1,0,1,10'h168, 0,4'hF,8'h00,2'd0, I|R, 0));
        apply(row(1,0,0,10'h000, 1,4'hF,8'h00,2'd3, N, 0));
        apply(row(1,0,0,10'h000, 3,4'h8,8'h20,2'd3, P, 0));
        // upper opcode bit set: no write, PC still advances, takes the fast path
        apply(row(1,0,1,10'h211, 0,4'hF,8'h00,2'd3, I|R, 1));
        apply(row(1,0,0,10'h000, 1,4'hF,8'h00,2'd3, N, 1));
        apply(row(1,0,0,10'h000, 3,4'hF,8'h00,2'd3, P, 1));
        // ALU ops keep all four steps
        apply(row(1,0,1,10'h00A, 0,4'hF,8'h00,2'd3, I|R, 2));
        apply(row(1,0,0,10'h000, 1,4'h1,8'h00,2'd0, A, 2));
        apply(row(1,0,0,10'h000, 2,4'h2,8'h00,2'd0, L, 2));
        apply(row(1,0,0,10'h000, 3,4'h9,8'h02,2'd0, P, 2));
        // REP r0,r0 back to back until the 4-bit counter wraps
        for (int k = 0; k < 13; k++) begin
            apply(row(1,0,1,10'h1C0, 0,4'hF,8'h00,(k == 0) ? 2'd0 : 2'd3, I|R, 16'((3 + k) % 16)));
            apply(row(1,0,0,10'h000, 1,4'hF,8'h00,2'd3, N, 16'((3 + k) % 16)));
            apply(row(1,0,0,10'h000, 3,4'h0,8'h01,2'd3, P, 16'((3 + k) % 16)));
        end
        apply(row(1,0,0,10'h000, 0,4'hF,8'h00,2'd3, R, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised successor of the processor's 4-step control logic.
- Owns its own step sequencer and instruction latch; no longer depends on an external step counter.
- Takes instruction words through a valid/ready handshake and drives the datapath strobes (register-file enables, bus mux, ALU, immediate, PC).
- Adds three capabilities: a clean HALT state instead of stopping simulation, an optional fast path for non-ALU instructions, and a retired-instruction counter.

Parameters:
- REG_ADDR_W, 3, register-address field width; NUM_REGS = 2**REG_ADDR_W; must be >= 2.
- OPCODE_W, 3, opcode field width; only the low 3 bits are decoded, upper bits must be 0 (nonzero upper bits decode as NO-OP: no write, PC still advances).
- FAST_NONALU, 0, when 1, non-ALU instructions skip step T2.
- CNT_W, 16, width of retired-instruction counter.
- IIN_W (derived), OPCODE_W+2*REG_ADDR_W; field layout {opcode, rx, ry}, MSB first.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- iin  in  IIN_W  instruction word.
- iin_valid  in  1  iin holds a valid instruction.
- iin_ready  out  1  sequencer can accept an instruction.
- mux_select  out  REG_ADDR_W+1  bus source select.
- regs_enable  out  NUM_REGS  one-hot register write enables.
- alu_op_select  out  2  ALU operation select.
- a_reg_enable  out  1  ALU input register load.
- alu_reg_enable  out  1  ALU output register load.
- imm_wr_enable  out  1  immediate register load.
- pc_wr_enable  out  1  PC update strobe.
- branch_select  out  1  current instruction is BEZ.
- halted  out  1  sequencer is in HALT.
- step  out  2  current step: FETCH=0, T1=1, T2=2, T3/HALT=3.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Opcodes (low 3 bits):
  - ADD=000, SUB=001, NAN=010, HLT=011, OUT=100, LDI=101, BEZ=110, REP=111.
  - ALU ops are ADD, SUB, NAN.
  - Write ops are all opcodes except OUT, BEZ and HLT.
- mux_select codes:
  - RX = {0,rx}; RY = {0,ry}.
  - IMM = {1,0...0}; ALU_OUT = {1,0...01}; NO_OUTPUT = all ones.
- State machine states: FETCH, T1, T2, T3, HALT.
- Reset:
  - Next state FETCH; instruction latch and retired cleared to 0.
  - While reset is high: iin_ready=0, all enables=0, mux_select=NO_OUTPUT, alu_op_select=2'b11, halted=0.
  - Reset overrides every state, including HALT and mid-instruction.
- FETCH:
  - iin_ready=1; imm_wr_enable = iin_valid.
  - On iin_valid, latch iin and go to T1; otherwise stay in FETCH.
  - mux_select=NO_OUTPUT.
- T1 (decode):
  - HLT goes to HALT.
  - ALU op: mux_select=RX, a_reg_enable=1, go to T2.
  - Non-ALU op: mux_select=NO_OUTPUT; go to T3 if FAST_NONALU=1, else T2.
- T2:
  - ALU op: mux_select=RY, alu_reg_enable=1.
  - Non-ALU op: mux_select=NO_OUTPUT.
  - Always go to T3.
- T3:
  - mux_select per opcode: OUT or BEZ = RX; REP = RY; LDI = IMM; ALU op = ALU_OUT.
  - regs_enable = one-hot(rx) for write ops, else 0.
  - pc_wr_enable=1; retired increments, wrapping at 2**CNT_W.
  - Go to FETCH.
- HALT:
  - halted=1; iin_ready=0; every enable and pc_wr_enable is 0; mux_select=NO_OUTPUT.
  - Only reset exits HALT. HLT is not counted in retired and does not advance the PC.
- Combinational outputs (derived from state and latched instruction; no registered delay):
  - alu_op_select = opcode[1:0] for ALU ops, else 2'b11.
  - branch_select = 1 in T1–T3 when the latched opcode is BEZ, else 0.
- Latency:
  - ALU ops and all ops with FAST_NONALU=0: 4 cycles, FETCH to FETCH, given iin_valid is already high.
  - Non-ALU ops with FAST_NONALU=1: 3 cycles.
- Outside FETCH, iin and iin_valid are ignored; the instruction is held stable in the latch.
- Throughput with iin_valid held high: one instruction per 4 cycles (3 on the fast path), with no bubble cycles.

Test Plan:
- Reset, then ADD r1,r2 (iin=9'h00A, iin_valid=1):
  - FETCH: imm_wr_enable=1.
  - T1: mux=4'h1, a_reg_enable=1, alu_op=00.
  - T2: mux=4'h2, alu_reg_enable=1.
  - T3: mux=4'h9, regs_enable=8'h02, pc_wr_enable=1; retired becomes 1.
- LDI r5 (9'h168) with FAST_NONALU=1:
  - Sequence is FETCH, T1, T3; T3: mux=4'h8, regs_enable=8'h20.
  - Next FETCH occurs 3 cycles after the first.
- BEZ r3 (9'h198) with FAST_NONALU=0:
  - branch_select=1 in T1–T3; T3: mux=4'h3, regs_enable=0, pc_wr_enable=1.
- HLT (9'h0C0):
  - T1 goes to HALT; halted=1 permanently and iin_ready=0.
  - iin_valid pulses are ignored; retired is unchanged.
  - Asserting reset for one cycle returns to FETCH with halted=0.
- iin_valid=0 for 5 cycles:
  - Stays in FETCH, iin_ready=1, no strobes.
- Reset asserted during T2 of SUB:
  - Next cycle is FETCH with all enables 0 and retired=0.
- Preload retired=16'hFFFF via 65535 REP instructions (or force), then one more REP:
  - retired wraps to 0.
